// File: rtl/id_check_param.sv
// ---------------------------------------------------------------------------
// id_check_param
//
// Parametrised user-ID checker. Collects NUM_DIGITS digits (first digit in
// the most significant position), then scans an external synchronous-read
// ID table one address per cycle. A hit grants access and reports the table
// index. A miss pulses IDFail. MAX_FAILS consecutive misses start a lockout
// that lasts LOCK_CYCLES clocks.
//
// Ports
//   Clk            system clock, rising edge
//   Rst            synchronous reset, active low
//   InputSwitches  current digit value
//   EnterPswd      one-cycle pulse, latches InputSwitches as the next digit
//   LogOutPulse    one-cycle pulse, logs out (granted) / cancels entry (collect)
//   RomData        table entry for the RomAddr of the previous cycle
//   RomAddr        table read address
//   IDOK           access granted (level)
//   InternalID     matched table index, 0 unless IDOK
//   IDFail         one-cycle pulse on a failed search
//   Locked         lockout active
//   Busy           search in progress
//   DigitCount     digits collected in the current entry
// ---------------------------------------------------------------------------
module id_check_param #(
    parameter int DIGIT_W     = 4,
    parameter int NUM_DIGITS  = 4,
    parameter int NUM_USERS   = 32,
    parameter int ADDR_W      = 5,
    parameter int MAX_FAILS   = 3,
    parameter int LOCK_CYCLES = 1024
) (
    input  logic                            Clk,
    input  logic                            Rst,
    input  logic [DIGIT_W-1:0]              InputSwitches,
    input  logic                            EnterPswd,
    input  logic                            LogOutPulse,
    input  logic [NUM_DIGITS*DIGIT_W-1:0]   RomData,
    output logic [ADDR_W-1:0]               RomAddr,
    output logic                            IDOK,
    output logic [ADDR_W-1:0]               InternalID,
    output logic                            IDFail,
    output logic                            Locked,
    output logic                            Busy,
    output logic [$clog2(NUM_DIGITS+1)-1:0] DigitCount
);

    localparam int ID_W   = NUM_DIGITS * DIGIT_W;
    localparam int CNT_W  = $clog2(NUM_DIGITS + 1);
    localparam int FAIL_W = $clog2(MAX_FAILS + 1);
    localparam int LOCK_W = $clog2(LOCK_CYCLES + 1);

    localparam logic [CNT_W-1:0]  LAST_DIGIT = CNT_W'(NUM_DIGITS - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(NUM_USERS - 1);
    localparam logic [FAIL_W-1:0] FAIL_MAX   = FAIL_W'(MAX_FAILS);
    localparam logic [LOCK_W-1:0] LOCK_LOAD  = LOCK_W'(LOCK_CYCLES);

    typedef enum logic [2:0] {
        st_collect,
        st_search,
        st_granted,
        st_fail,
        st_locked
    } state_t;

    state_t              state,     state_nxt;
    logic [ID_W-1:0]     id_reg,    id_nxt;
    logic [CNT_W-1:0]    digit_cnt, digit_nxt;
    logic [ADDR_W-1:0]   rom_addr,  addr_nxt;
    logic                cmp_valid, cmp_valid_nxt;   // RomData holds a real entry this cycle
    logic [ADDR_W-1:0]   cmp_idx,   cmp_idx_nxt;     // address whose entry is on RomData
    logic [ADDR_W-1:0]   user_idx,  user_nxt;
    logic [FAIL_W-1:0]   fail_cnt,  fail_nxt;
    logic [LOCK_W-1:0]   lock_cnt,  lock_nxt;

    logic                hit;
    logic [FAIL_W-1:0]   fail_inc;

    // All-ones entries are empty slots and must never match, even if the
    // collected ID happens to be all ones as well.
    assign hit      = (RomData == id_reg) && (RomData != '1);
    assign fail_inc = (fail_cnt == FAIL_MAX) ? fail_cnt : fail_cnt + 1'b1;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // it unassigned; otherwise synthesis infers a latch.
        state_nxt     = state;
        id_nxt        = id_reg;
        digit_nxt     = digit_cnt;
        addr_nxt      = rom_addr;
        cmp_valid_nxt = 1'b0;
        cmp_idx_nxt   = cmp_idx;
        user_nxt      = user_idx;
        fail_nxt      = fail_cnt;
        lock_nxt      = lock_cnt;

        unique case (state)
            st_collect: begin
                if (LogOutPulse) begin
                    id_nxt    = '0;
                    digit_nxt = '0;
                end else if (EnterPswd) begin
                    id_nxt = (id_reg << DIGIT_W) | ID_W'(InputSwitches);
                    if (digit_cnt == LAST_DIGIT) begin
                        state_nxt = st_search;
                        digit_nxt = '0;
                        addr_nxt  = '0;
                    end else begin
                        digit_nxt = digit_cnt + 1'b1;
                    end
                end
            end

            st_search: begin
                // Address is issued now; its data is compared next cycle.
                cmp_valid_nxt = 1'b1;
                cmp_idx_nxt   = rom_addr;
                if (rom_addr != LAST_ADDR)
                    addr_nxt = rom_addr + 1'b1;
                if (cmp_valid) begin
                    if (hit) begin
                        state_nxt = st_granted;
                        user_nxt  = cmp_idx;
                        fail_nxt  = '0;
                    end else if (cmp_idx == LAST_ADDR) begin
                        state_nxt = st_fail;
                    end
                end
            end

            st_granted: begin
                if (LogOutPulse) begin
                    state_nxt = st_collect;
                    user_nxt  = '0;
                end
            end

            st_fail: begin
                fail_nxt = fail_inc;
                if (fail_inc == FAIL_MAX) begin
                    state_nxt = st_locked;
                    lock_nxt  = LOCK_LOAD;
                end else begin
                    state_nxt = st_collect;
                end
            end

            st_locked: begin
                // Counter runs LOCK_CYCLES..1, giving exactly LOCK_CYCLES cycles.
                if (lock_cnt <= LOCK_W'(1)) begin
                    state_nxt = st_collect;
                    lock_nxt  = '0;
                    fail_nxt  = '0;
                end else begin
                    lock_nxt = lock_cnt - 1'b1;
                end
            end

            default: state_nxt = st_collect;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state     <= st_collect;
            id_reg    <= '0;
            digit_cnt <= '0;
            rom_addr  <= '0;
            cmp_valid <= 1'b0;
            cmp_idx   <= '0;
            user_idx  <= '0;
            fail_cnt  <= '0;
            lock_cnt  <= '0;
        end else begin
            state     <= state_nxt;
            id_reg    <= id_nxt;
            digit_cnt <= digit_nxt;
            rom_addr  <= addr_nxt;
            cmp_valid <= cmp_valid_nxt;
            cmp_idx   <= cmp_idx_nxt;
            user_idx  <= user_nxt;
            fail_cnt  <= fail_nxt;
            lock_cnt  <= lock_nxt;
        end
    end

    assign RomAddr    = rom_addr;
    assign IDOK       = (state == st_granted);
    assign InternalID = user_idx;
    assign IDFail     = (state == st_fail);
    assign Locked     = (state == st_locked);
    assign Busy       = (state == st_search);
    assign DigitCount = digit_cnt;

endmodule

// File: tb/tb_id_check_param.sv
// ---------------------------------------------------------------------------
// tb_id_check_param
//
// Self-checking bench for id_check_param (LOCK_CYCLES reduced to 16). The
// reference model is a table lookup for the first non-empty matching entry
// plus a count of consecutive failures; expected cycle positions follow
// directly from the documented search timing.
// ---------------------------------------------------------------------------
module tb_id_check_param;

    localparam int NUM_USERS   = 32;
    localparam int MAX_FAILS   = 3;
    localparam int LOCK_CYCLES = 16;

    logic        Clk;
    logic        Rst;
    logic [3:0]  InputSwitches;
    logic        EnterPswd;
    logic        LogOutPulse;
    logic [15:0] RomData;
    logic [4:0]  RomAddr;
    logic        IDOK;
    logic [4:0]  InternalID;
    logic        IDFail;
    logic        Locked;
    logic        Busy;
    logic [2:0]  DigitCount;

    id_check_param #(
        .DIGIT_W     (4),
        .NUM_DIGITS  (4),
        .NUM_USERS   (NUM_USERS),
        .ADDR_W      (5),
        .MAX_FAILS   (MAX_FAILS),
        .LOCK_CYCLES (LOCK_CYCLES)
    ) dut (
        .Clk           (Clk),
        .Rst           (Rst),
        .InputSwitches (InputSwitches),
        .EnterPswd     (EnterPswd),
        .LogOutPulse   (LogOutPulse),
        .RomData       (RomData),
        .RomAddr       (RomAddr),
        .IDOK          (IDOK),
        .InternalID    (InternalID),
        .IDFail        (IDFail),
        .Locked        (Locked),
        .Busy          (Busy),
        .DigitCount    (DigitCount)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // External ID table with one-cycle synchronous read.
    logic [15:0] tbl [NUM_USERS];
    always @(posedge Clk) RomData <= tbl[RomAddr];

    int checks   = 0;
    int failures = 0;
    int fail_m   = 0;   // model: consecutive failed searches

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance one rising edge and sample just after it.
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    function automatic int find_user(input logic [15:0] id);
        for (int i = 0; i < NUM_USERS; i++)
            if (tbl[i] == id && tbl[i] != 16'hFFFF) return i;
        return -1;
    endfunction

    task automatic press(input logic [3:0] d, input int exp_cnt);
        InputSwitches = d;
        EnterPswd     = 1'b1;
        step();
        EnterPswd     = 1'b0;
        check("digit_count", {29'd0, DigitCount}, exp_cnt);
    endtask

    task automatic enter_id(input logic [15:0] id);
        for (int i = 0; i < 4; i++)
            press(id[15-4*i -: 4], (i == 3) ? 0 : i + 1);
    endtask

    // Enter an ID and follow the whole search, including any lockout.
    task automatic do_attempt(input logic [15:0] id);
        int  idx;
        logic bad;
        idx = find_user(id);
        enter_id(id);
        check("busy_rise", {31'd0, Busy}, 1);
        check("addr_start", {27'd0, RomAddr}, 0);
        bad = 1'b0;
        if (idx >= 0) begin
            for (int k = 0; k < idx + 1; k++) begin
                step();
                if (IDOK || IDFail || !Busy) bad = 1'b1;
            end
            step();
            check("search_quiet", {31'd0, bad}, 0);
            check("grant_idok", {31'd0, IDOK}, 1);
            check("grant_index", {27'd0, InternalID}, idx);
            check("grant_busy", {31'd0, Busy}, 0);
            fail_m = 0;
        end else begin
            for (int k = 0; k < NUM_USERS; k++) begin
                step();
                if (IDOK || IDFail || !Busy) bad = 1'b1;
            end
            step();
            check("search_quiet", {31'd0, bad}, 0);
            check("fail_pulse", {31'd0, IDFail}, 1);
            check("fail_busy", {31'd0, Busy}, 0);
            check("fail_idok", {31'd0, IDOK}, 0);
            check("fail_addr_hold", {27'd0, RomAddr}, NUM_USERS - 1);
            step();
            check("fail_single", {31'd0, IDFail}, 0);
            fail_m++;
            if (fail_m == MAX_FAILS) begin
                check("lock_start", {31'd0, Locked}, 1);
                bad = 1'b0;
                for (int k = 1; k < LOCK_CYCLES; k++) begin
                    InputSwitches = 4'($urandom);
                    EnterPswd     = 1'($urandom);
                    step();
                    if (!Locked || DigitCount != 0) bad = 1'b1;
                end
                InputSwitches = 4'($urandom);
                EnterPswd     = 1'($urandom);
                step();
                EnterPswd = 1'b0;
                check("lock_hold", {31'd0, bad}, 0);
                check("lock_end", {31'd0, Locked}, 0);
                check("lock_digits_ignored", {29'd0, DigitCount}, 0);
                fail_m = 0;
            end else begin
                check("no_lock", {31'd0, Locked}, 0);
                check("fail_digit_count", {29'd0, DigitCount}, 0);
            end
        end
    endtask

    // From GRANTED: digits ignored, then logout.
    task automatic logout();
        logic [4:0] id_before;
        id_before     = InternalID;
        InputSwitches = 4'($urandom);
        EnterPswd     = 1'b1;
        step();
        EnterPswd = 1'b0;
        check("granted_ignores_digit", {29'd0, DigitCount}, 0);
        check("granted_holds_index", {27'd0, InternalID}, {27'd0, id_before});
        check("granted_held", {31'd0, IDOK}, 1);
        LogOutPulse = 1'b1;
        step();
        LogOutPulse = 1'b0;
        check("logout_idok", {31'd0, IDOK}, 0);
        check("logout_index", {27'd0, InternalID}, 0);
    endtask

    // Partial entry cancelled by LogOutPulse together with EnterPswd.
    task automatic cancel(input int n);
        for (int i = 0; i < n; i++) press(4'($urandom), i + 1);
        InputSwitches = 4'($urandom);
        EnterPswd     = 1'b1;
        LogOutPulse   = 1'b1;
        step();
        EnterPswd   = 1'b0;
        LogOutPulse = 1'b0;
        check("cancel_count", {29'd0, DigitCount}, 0);
    endtask

    initial begin
        logic        bad;
        logic [15:0] id;
        Rst           = 1'b0;
        InputSwitches = 4'd0;
        EnterPswd     = 1'b0;
        LogOutPulse   = 1'b0;
        for (int i = 0; i < NUM_USERS; i++) tbl[i] = 16'hFFFF;
        tbl[5] = 16'h8523;

        // Reset held with activity on the inputs.
        bad = 1'b0;
        for (int i = 0; i < 7; i++) begin
            EnterPswd     = ~EnterPswd;
            InputSwitches = 4'($urandom);
            step();
            if (IDOK || IDFail || Locked || Busy || InternalID != 0 ||
                RomAddr != 0 || DigitCount != 0) bad = 1'b1;
        end
        check("reset_outputs", {31'd0, bad}, 0);
        EnterPswd = 1'b0;
        Rst       = 1'b1;
        step();
        step();
        check("idle_idok", {31'd0, IDOK}, 0);
        check("idle_busy", {31'd0, Busy}, 0);
        check("idle_locked", {31'd0, Locked}, 0);
        check("idle_count", {29'd0, DigitCount}, 0);
        check("idle_addr", {27'd0, RomAddr}, 0);

        // Grant, logout.
        do_attempt(16'h8523);
        logout();

        // Reject, then grant.
        do_attempt(16'h8522);
        do_attempt(16'h8523);
        logout();

        // Lockout after three consecutive misses, then grant.
        do_attempt(16'h8522);
        do_attempt(16'h1234);
        do_attempt(16'hFFFF);
        do_attempt(16'h8523);
        logout();

        // Cancel of a partial entry.
        cancel(2);
        do_attempt(16'h8523);
        logout();

        // Reset mid-search clears the fail counter.
        do_attempt(16'h0000);
        do_attempt(16'h0001);
        enter_id(16'h0002);
        for (int i = 0; i < 9; i++) step();
        Rst = 1'b0;
        step();
        Rst = 1'b1;
        check("midrst_busy", {31'd0, Busy}, 0);
        check("midrst_addr", {27'd0, RomAddr}, 0);
        check("midrst_idok", {31'd0, IDOK}, 0);
        check("midrst_fail", {31'd0, IDFail}, 0);
        fail_m = 0;
        bad    = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (IDFail || IDOK || Busy) bad = 1'b1;
        end
        check("midrst_quiet", {31'd0, bad}, 0);
        do_attempt(16'h0003);   // only the first miss since reset: no lockout

        // Randomized tables and IDs.
        for (int it = 0; it < 25; it++) begin
            for (int i = 0; i < NUM_USERS; i++)
                tbl[i] = ($urandom_range(0, 9) < 3) ? 16'hFFFF : 16'($urandom);
            if ($urandom_range(0, 1) == 1)
                tbl[$urandom_range(16, NUM_USERS - 1)] = tbl[$urandom_range(0, 15)];
            if ($urandom_range(0, 9) < 6) id = tbl[$urandom_range(0, NUM_USERS - 1)];
            else                          id = 16'($urandom);
            if ($urandom_range(0, 3) == 0) cancel($urandom_range(0, 3));
            do_attempt(id);
            if (find_user(id) >= 0) logout();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/id_check_param.md
# id_check_param

Parametrised user-ID checker for the access controller's multi-user authentication path. It collects a fixed-length ID one digit at a time from the input switches, qualified by single-cycle EnterPswd pulses. It then searches an external synchronous-read ID table sequentially and either grants access (IDOK plus the internal user index) or reports failure. Beyond the single-user checker, it adds configurable digit width, ID length and table depth, a failed-attempt counter with timed lockout, and digit-entry cancel via LogOutPulse.

## Interface
- DIGIT_W, 4: bits per entered digit.
- NUM_DIGITS, 4: digits per ID.
- NUM_USERS, 32: table entries searched, addresses 0..NUM_USERS-1.
- ADDR_W, 5: table address / InternalID width; NUM_USERS <= 2^ADDR_W.
- MAX_FAILS, 3: consecutive failures that trigger lockout; >= 1.
- LOCK_CYCLES, 1024: lockout duration in clocks; >= 1.
- Clk  in  1  system clock; all logic on rising edge.
- Rst  in  1  synchronous, active-low reset.
- InputSwitches  in  DIGIT_W  current digit value.
- EnterPswd  in  1  one-cycle pulse, already debounced; latches InputSwitches as the next digit.
- LogOutPulse  in  1  one-cycle pulse; logs out when granted, cancels partial entry when collecting.
- RomData  in  NUM_DIGITS*DIGIT_W  table entry for the RomAddr of the previous cycle.
- RomAddr  out  ADDR_W  table read address.
- IDOK  out  1  access granted, level.
- InternalID  out  ADDR_W  matched table index; 0 unless IDOK.
- IDFail  out  1  one-cycle pulse on a failed search.
- Locked  out  1  lockout active.
- Busy  out  1  search in progress.
- DigitCount  out  $clog2(NUM_DIGITS+1)  digits collected in the current entry.

## Operation
- States: COLLECT, SEARCH, GRANTED, FAIL, LOCKED.
- COLLECT:
  - Each EnterPswd shifts InputSwitches into the ID register. The first digit lands in the most significant DIGIT_W bits; DigitCount increments.
  - On the NUM_DIGITS-th pulse, go to SEARCH with RomAddr=0 and DigitCount cleared.
  - LogOutPulse clears the ID register and DigitCount.
- SEARCH:
  - RomAddr increments every cycle. RomData is compared against the ID register one cycle after the address is issued.
  - An entry of all ones is an empty slot and never matches.
  - On the first match at address i, go to GRANTED with InternalID=i and the fail counter cleared.
  - If the compare for address NUM_USERS-1 misses, go to FAIL.
  - EnterPswd and LogOutPulse are ignored.
- FAIL (1 cycle): IDFail=1 and the fail counter increments.
  - If the counter reaches MAX_FAILS, go to LOCKED and load the lock counter with LOCK_CYCLES.
  - Otherwise, go to COLLECT.
- GRANTED: IDOK=1 and EnterPswd is ignored. LogOutPulse returns to COLLECT with IDOK=0 and InternalID=0; the fail counter is untouched.
- LOCKED: Locked=1 and EnterPswd/LogOutPulse are ignored. The lock counter decrements each cycle; at 0, go to COLLECT with the fail counter cleared.
- Simultaneous EnterPswd and LogOutPulse in COLLECT: LogOutPulse wins and the digit is discarded.

## Timing
- Reset values (Rst=0 at a rising edge):
  - state COLLECT
  - IDOK, IDFail, Locked, Busy: 0
  - InternalID, RomAddr, DigitCount: 0
  - ID register, fail counter, lock counter: 0
- Reset applied mid-search or mid-lockout aborts immediately to the reset values.
- Let T be the edge where the final EnterPswd is sampled:
  - T+1: Busy=1, RomAddr=0.
  - Entry i is compared at T+2+i.
  - A match at i gives IDOK=1 and InternalID=i from T+3+i; Busy=0 in the same cycle.
  - No match gives IDFail high for exactly the cycle T+3+(NUM_USERS-1), with Busy=0 from that cycle.
- DigitCount updates the cycle after each accepted EnterPswd.
- Locked is high for exactly LOCK_CYCLES cycles, starting the cycle after the IDFail pulse that hit MAX_FAILS. EnterPswd is accepted again on the first cycle with Locked=0.
- Logout: IDOK falls the cycle after LogOutPulse is sampled.
- RomAddr stays at NUM_USERS-1 after a full search and returns to 0 on the next SEARCH entry; no wrap-around within a search.
- Fail counter saturates at MAX_FAILS; arithmetic is unsigned.

## Test plan
- Reset: hold Rst=0 for 7 cycles with EnterPswd toggling -> all outputs 0 and DigitCount stays 0; after release, 2 cycles of idle leave outputs unchanged.
- Grant: defaults, table[5]=16'h8523, others 16'hFFFF; enter 8,5,2,3 -> Busy rises at T+1, IDOK=1 and InternalID=5 at T+8, IDFail never asserts.
- Reject: same table, enter 8,5,2,2 -> IDFail single pulse at T+34, IDOK stays 0, DigitCount=0, then a correct 8,5,2,3 entry grants with InternalID=5.
- Lockout: MAX_FAILS=3, LOCK_CYCLES=16; three wrong IDs ->
  - Locked=1 for exactly 16 cycles after the third IDFail.
  - Digits entered meanwhile are ignored (DigitCount stays 0).
  - Afterwards 8,5,2,3 grants.
- Logout/cancel:
  - Granted, then LogOutPulse -> IDOK=0 and InternalID=0 next cycle.
  - Two digits entered, then LogOutPulse together with EnterPswd -> DigitCount=0.
- Reset mid-search: assert Rst=0 at T+10 of a search -> Busy=0, RomAddr=0, no IDFail or IDOK, fail counter 0.
